cfg_info_responder: RTL and testbench
=====================================

# cfg_info_responder

Read-only responder that exposes the derived CVA6 configuration words to debug and software. The words are made available through a simple req/gnt/rvalid read port. It sits beside the CSR/debug interconnect and consumes the static configuration snapshot produced at elaboration. It folds that snapshot into a checksum after reset or on request, and flags any change between scans.

## Interface

Parameters:
- NrWords, 16 — number of 32-bit configuration words; legal range 2..64.
- AW, $clog2(NrWords+2) — read address width in words (derived, not overridden).
- MagicId, 32'hC0F1_6000 — ID pattern; returned word is MagicId | NrWords.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_words_i  in  NrWords*32  configuration snapshot; word k is bits [32k+31:32k]; quasi-static.
- rescan_i  in  1  single-cycle pulse; restarts the checksum scan.
- req_i  in  1  read request.
- addr_i  in  AW  word index of the read.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  read response valid.
- rdata_o  out  32  read data.
- err_o  out  1  response error; qualified by rvalid_o.
- ready_o  out  1  checksum valid; responder accepting reads.
- changed_o  out  1  sticky flag; a rescan produced a checksum different from the previous one.

## Operation

- FSM states: SCAN, SERVE.
- Reset enters SCAN with idx=0, acc=0.
- SCAN: one word per cycle, index 0 upward.
  - acc <= rotl1(acc) ^ cfg_words_i[idx].
  - After word NrWords-1: checksum <= final acc, go to SERVE.
  - If this is not the first scan since reset, changed_o is set when the new checksum differs from the old one.
- SERVE: gnt_o = req_i. Requests are not granted in SCAN.
- Address map:
  - 0..NrWords-1: config word.
  - NrWords: checksum.
  - NrWords+1: MagicId | NrWords.
  - Any other address: rdata 0, err_o=1.
- rescan_i in SERVE: go to SCAN, idx=0, acc=0, ready_o falls the next cycle.
- rescan_i in SCAN: restarts the scan from idx 0.
- rescan_i and req_i in the same cycle: rescan wins and the request is not granted.
- A response already accepted is still delivered the next cycle.
- The first scan after reset never sets changed_o.
- changed_o clears only on reset.
- Throughput in SERVE: one read per cycle, back-to-back, no bubbles.

## Timing

- Values during reset:
  - 0: gnt_o, rvalid_o, rdata_o, err_o, ready_o, changed_o.
  - Internal: checksum=0, state=SCAN.
- Scan length: NrWords cycles. Cycle 1 is the first edge with rst_i low, and it folds word 0.
  - ready_o rises after the NrWords-th such edge.
  - gnt_o can assert combinationally in that same cycle.
- Read latency: request granted at edge N, so rvalid_o, rdata_o and err_o are valid for exactly one cycle after edge N.
- rdata_o and err_o hold their last values when rvalid_o=0; rvalid_o is the only qualifier.
- gnt_o is combinational from req_i and state; all other outputs are registered.
- Reset asserted mid-scan or mid-response: all outputs return to reset values on that edge. An in-flight rvalid is dropped.
- cfg_words_i changes during SCAN are sampled per word as indexed; no stall.

## Test plan

- NrWords=4, words 1,2,3,4, reset released → ready_o high 4 cycles later; read addr 4 → rdata 0x00000002, err_o=0, changed_o=0.
- After ready, back-to-back reads at addr 0,1,2,3,5 on consecutive cycles:
  - gnt_o high every cycle.
  - rdata 1,2,3,4 then 0xC0F16004, each one cycle after its grant.
  - err_o=0 throughout.
- Read addr 6 and addr 7 (out of range, AW=3) → rdata 0, err_o=1, rvalid_o for one cycle each.
- Change word 3 to 5, pulse rescan_i → ready_o low for 4 cycles, then checksum 0x00000003 (rotl1(0)^5 → (0^5)... = 0x00000003 for words 1,2,3,5); changed_o=1 and stays 1.
- Same-cycle cases:
  - rescan_i and req_i together → gnt_o=0, no response.
  - req granted the cycle before rescan → its response still arrives.
  - Rescan with unchanged words → changed_o unchanged.
- Assert rst_i while SERVE has an outstanding grant → rvalid_o=0 the next cycle, all outputs 0, new scan starts after release.

Source files
------------

// File: rtl/cfg_info_responder.sv
// Read-only responder exposing the static configuration snapshot, its rolling
// checksum and an ID word over a req/gnt/rvalid port; flags checksum changes.
module cfg_info_responder #(
    parameter int unsigned NrWords = 16,
    parameter int unsigned AW      = $clog2(NrWords + 2),
    parameter logic [31:0] MagicId = 32'hC0F1_6000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NrWords*32-1:0] cfg_words_i,
    input  logic                  rescan_i,
    input  logic                  req_i,
    input  logic [AW-1:0]         addr_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  ready_o,
    output logic                  changed_o
);

    localparam int unsigned IW = $clog2(NrWords);

    localparam logic [0:0] ST_SCAN  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    logic [0:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [31:0]   r_acc;
    logic [31:0]   r_checksum;
    logic          r_scanned;
    logic          r_changed;
    logic          r_rvalid;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic [31:0]   w_scan_word;
    logic [31:0]   w_acc_next;
    logic [31:0]   w_rd_data;
    logic          w_rd_err;
    logic          w_gnt;

    // Rescan takes priority over a same-cycle request; nothing is granted in reset.
    assign w_gnt = req_i && (r_state == ST_SERVE) && !rescan_i && !rst_i;

    always_comb begin
        w_scan_word = '0;
        for (int unsigned k = 0; k < NrWords; k++) begin
            if (r_idx == IW'(k)) begin
                w_scan_word = cfg_words_i[k*32 +: 32];
            end
        end
    end

    assign w_acc_next = {r_acc[30:0], r_acc[31]} ^ w_scan_word;

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b1;
        for (int unsigned k = 0; k < NrWords; k++) begin
            if (addr_i == AW'(k)) begin
                w_rd_data = cfg_words_i[k*32 +: 32];
                w_rd_err  = 1'b0;
            end
        end
        if (addr_i == AW'(NrWords)) begin
            w_rd_data = r_checksum;
            w_rd_err  = 1'b0;
        end
        if (addr_i == AW'(NrWords + 1)) begin
            w_rd_data = MagicId | 32'(NrWords);
            w_rd_err  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_SCAN;
            r_idx      <= '0;
            r_acc      <= '0;
            r_checksum <= '0;
            r_scanned  <= 1'b0;
            r_changed  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_gnt) begin
                r_rdata <= w_rd_data;
                r_err   <= w_rd_err;
            end

            if (r_state == ST_SCAN) begin
                if (rescan_i) begin
                    r_idx <= '0;
                    r_acc <= '0;
                end else if (r_idx == IW'(NrWords - 1)) begin
                    // Only compare against a checksum produced by an earlier scan.
                    r_checksum <= w_acc_next;
                    r_scanned  <= 1'b1;
                    if (r_scanned && (w_acc_next != r_checksum)) begin
                        r_changed <= 1'b1;
                    end
                    r_idx   <= '0;
                    r_acc   <= '0;
                    r_state <= ST_SERVE;
                end else begin
                    r_idx <= r_idx + 1'b1;
                    r_acc <= w_acc_next;
                end
            end else if (rescan_i) begin
                r_state <= ST_SCAN;
                r_idx   <= '0;
                r_acc   <= '0;
            end
        end
    end

    assign gnt_o     = w_gnt;
    assign rvalid_o  = r_rvalid;
    assign rdata_o   = r_rdata;
    assign err_o     = r_err;
    assign ready_o   = (r_state == ST_SERVE);
    assign changed_o = r_changed;

endmodule

// File: tb/tb_cfg_info_responder.sv
// Directed bench for cfg_info_responder with NrWords=4 and hand-computed
// checksums (1,2,3,4 -> 0x2; 1,2,3,5 -> 0x3).
module tb_cfg_info_responder;

    localparam int unsigned NW = 4;
    localparam int unsigned AW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [NW*32-1:0] cfg;
    logic           rescan;
    logic           req;
    logic [AW-1:0]  addr;
    logic           gnt;
    logic           rvalid;
    logic [31:0]    rdata;
    logic           err;
    logic           ready;
    logic           changed;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    cfg_info_responder #(.NrWords(NW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_words_i(cfg),
        .rescan_i   (rescan),
        .req_i      (req),
        .addr_i     (addr),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .err_o      (err),
        .ready_o    (ready),
        .changed_o  (changed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one granted read and check its response one cycle later.
    task automatic read(input string tag, input logic [AW-1:0] a,
                        input logic [31:0] exp_data, input logic exp_err);
        req  = 1'b1;
        addr = a;
        #1;
        check({tag, "_gnt"}, 32'(gnt), 32'd1);
        tick();
        req = 1'b0;
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "_rdata"}, rdata, exp_data);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    logic [AW-1:0] seq_addr [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    logic [31:0]   seq_data [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'hC0F1_6004};

    initial begin
        rst    = 1'b1;
        rescan = 1'b0;
        req    = 1'b0;
        addr   = '0;
        cfg    = {32'd4, 32'd3, 32'd2, 32'd1};
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_changed", 32'(changed), 32'd0);

        // First scan: ready only after the 4th edge with reset low.
        rst = 1'b0;
        req = 1'b1;
        tick();
        #1;
        check("scan_no_gnt", 32'(gnt), 32'd0);
        tick();
        tick();
        check("scan3_ready", 32'(ready), 32'd0);
        check("scan_no_rvalid", 32'(rvalid), 32'd0);
        req = 1'b0;
        tick();
        check("scan4_ready", 32'(ready), 32'd1);

        read("csum0", 3'd4, 32'h0000_0002, 1'b0);
        check("csum0_changed", 32'(changed), 32'd0);

        // Back-to-back reads, one per cycle.
        for (int i = 0; i < 5; i++) begin
            req  = 1'b1;
            addr = seq_addr[i];
            #1;
            check("b2b_gnt", 32'(gnt), 32'd1);
            tick();
            check("b2b_rvalid", 32'(rvalid), 32'd1);
            check("b2b_rdata", rdata, seq_data[i]);
            check("b2b_err", 32'(err), 32'd0);
        end
        req = 1'b0;
        tick();
        check("idle_rvalid", 32'(rvalid), 32'd0);
        check("idle_rdata_hold", rdata, 32'hC0F1_6004);

        read("oor6", 3'd6, 32'd0, 1'b1);
        tick();
        check("oor6_single", 32'(rvalid), 32'd0);
        check("oor6_err_hold", 32'(err), 32'd1);
        read("oor7", 3'd7, 32'd0, 1'b1);
        tick();
        check("oor7_single", 32'(rvalid), 32'd0);

        // Rescan with unchanged words must not set changed.
        rescan = 1'b1;
        tick();
        rescan = 1'b0;
        check("same_rescan_ready", 32'(ready), 32'd0);
        tick(); tick(); tick(); tick();
        check("same_rescan_ready_back", 32'(ready), 32'd1);
        check("same_rescan_changed", 32'(changed), 32'd0);
        read("csum_same", 3'd4, 32'h0000_0002, 1'b0);

        // Change word 3 and rescan: ready low for 4 cycles, checksum 0x3.
        cfg[96 +: 32] = 32'd5;
        rescan = 1'b1;
        tick();
        rescan = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("chg_ready_low", 32'(ready), 32'd0);
            tick();
        end
        check("chg_ready_high", 32'(ready), 32'd1);
        check("chg_changed", 32'(changed), 32'd1);
        read("csum1", 3'd4, 32'h0000_0003, 1'b0);

        // Rescan and request together: rescan wins, no response.
        req    = 1'b1;
        addr   = 3'd0;
        rescan = 1'b1;
        #1;
        check("coll_gnt", 32'(gnt), 32'd0);
        tick();
        req    = 1'b0;
        rescan = 1'b0;
        check("coll_rvalid", 32'(rvalid), 32'd0);
        check("coll_ready", 32'(ready), 32'd0);
        tick(); tick(); tick(); tick();
        check("coll_ready_back", 32'(ready), 32'd1);
        check("coll_changed_sticky", 32'(changed), 32'd1);

        // Request granted the cycle before a rescan still gets its response.
        req  = 1'b1;
        addr = 3'd1;
        tick();
        req    = 1'b0;
        rescan = 1'b1;
        #1;
        check("pre_rescan_rvalid", 32'(rvalid), 32'd1);
        check("pre_rescan_rdata", rdata, 32'd2);
        tick();
        rescan = 1'b0;
        check("pre_rescan_ready", 32'(ready), 32'd0);
        check("pre_rescan_rvalid_drop", 32'(rvalid), 32'd0);
        tick(); tick(); tick(); tick();
        check("pre_rescan_ready_back", 32'(ready), 32'd1);

        // Reset while a request is outstanding drops the response.
        req  = 1'b1;
        addr = 3'd2;
        #1;
        check("pre_rst_gnt", 32'(gnt), 32'd1);
        rst = 1'b1;
        #1;
        check("in_rst_gnt", 32'(gnt), 32'd0);
        tick();
        req = 1'b0;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_changed", 32'(changed), 32'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("post_rst_scan3", 32'(ready), 32'd0);
        tick();
        check("post_rst_ready", 32'(ready), 32'd1);
        check("post_rst_changed", 32'(changed), 32'd0);
        read("csum_post_rst", 3'd4, 32'h0000_0003, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
